// File: rtl/ahb_slave_regfile.sv
// AHB-Lite responder holding REG_NUM little-endian 32-bit registers with
// programmable wait states, byte/halfword/word lanes and two-cycle ERROR.
module ahb_slave_regfile #(
  parameter int unsigned AHB_ADDR_WIDTH    = 32,
  parameter int unsigned SLAVE_SPACE_WIDTH = 10,
  parameter int unsigned REG_NUM           = 16,
  parameter int unsigned WAIT_STATES       = 0
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  input  logic                      ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic                      ahb_write_in,
  input  logic [2:0]                ahb_size_in,
  input  logic [31:0]               ahb_wdata_in,
  input  logic                      ahb_ready_in,
  output logic                      ahb_readyout_out,
  output logic                      ahb_resp_out,
  output logic [31:0]               ahb_rdata_out
);

  localparam int unsigned OFF_W = SLAVE_SPACE_WIDTH;
  localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         be_q;
  logic               write_q;
  logic               readyout_q;
  logic               resp_q;
  logic [31:0]        regs_q [REG_NUM];

  logic [OFF_W-1:0]   offset_c;
  logic               accept_c;
  logic               illegal_c;
  logic [3:0]         be_c;
  logic               unused_c;

  assign offset_c = ahb_addr_in[OFF_W-1:0];
  assign accept_c = ahb_sel_in & ahb_ready_in & ahb_trans_in[1];
  assign unused_c = ^{ahb_addr_in[AHB_ADDR_WIDTH-1:OFF_W], ahb_trans_in[0]};

  // Address-phase legality: size, window range and natural alignment.
  always_comb begin
    illegal_c = 1'b0;
    if (ahb_size_in > 3'd2)
      illegal_c = 1'b1;
    if (32'(offset_c) >= 32'(REG_NUM * 4))
      illegal_c = 1'b1;
    if ((ahb_size_in == 3'd1) && offset_c[0])
      illegal_c = 1'b1;
    if ((ahb_size_in == 3'd2) && (offset_c[1:0] != 2'b00))
      illegal_c = 1'b1;
  end

  always_comb begin
    be_c = 4'b1111;
    case (ahb_size_in)
      3'd0:    be_c = 4'b0001 << offset_c[1:0];
      3'd1:    be_c = offset_c[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
  end

  // Response FSM, address-phase capture and register commit.
  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      be_q       <= '0;
      write_q    <= 1'b0;
      readyout_q <= 1'b1;
      resp_q     <= 1'b0;
      for (int i = 0; i < int'(REG_NUM); i++)
        regs_q[i] <= '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q    <= ST_DONE;
            readyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_ERR1: begin
          state_q    <= ST_ERR2;
          readyout_q <= 1'b1;
          resp_q     <= 1'b1;
        end
        default: begin
          if ((state_q == ST_DONE) && write_q) begin
            for (int b = 0; b < 4; b++)
              if (be_q[b])
                regs_q[idx_q][8*b +: 8] <= ahb_wdata_in[8*b +: 8];
          end
          // The closing cycle of a transfer doubles as the next address phase.
          if (accept_c) begin
            idx_q   <= offset_c[IDX_W+1:2];
            be_q    <= be_c;
            write_q <= ahb_write_in;
            if (illegal_c) begin
              state_q    <= ST_ERR1;
              readyout_q <= 1'b0;
              resp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q    <= ST_WAIT;
              cnt_q      <= CNT_W'(WAIT_STATES - 1);
              readyout_q <= 1'b0;
              resp_q     <= 1'b0;
            end else begin
              state_q    <= ST_DONE;
              readyout_q <= 1'b1;
              resp_q     <= 1'b0;
            end
          end else begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            readyout_q <= 1'b1;
            resp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ahb_readyout_out = readyout_q;
  assign ahb_resp_out     = resp_q;
  assign ahb_rdata_out    = ((state_q == ST_DONE) && !write_q) ? regs_q[idx_q] : 32'h0;

endmodule
